// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, control bundle type and decode helpers
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // execute result mux: ALU, multiplier, link address (pc+4), pc adder
    localparam logic [1:0] EX_ALU   = 2'd0;
    localparam logic [1:0] EX_MUL   = 2'd1;
    localparam logic [1:0] EX_LINK  = 2'd2;
    localparam logic [1:0] EX_PCADD = 2'd3;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
        ALU_PASS_B, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [1:0] reg_read_en;        // [0] rs1, [1] rs2
        logic       reg_write_en;
        imm_type_e  imm_type;
        logic       alu_en;
        alu_op_e    alu_op;
        logic       mul_en;
        logic       alu_mul_data2_sel;  // 1 = immediate as second operand
        logic       pcadder_op1_sel;    // 0 = pc, 1 = rs1
        logic       pcadder_op2_sel;    // 0 = constant 4, 1 = immediate
        logic [1:0] execute_out_sel;
        logic       dmem_read_en;
        logic       dmem_write_en;
        logic       reg_writedata_sel;  // 0 = execute result, 1 = load data
        logic       illegal;
    } ctrl_t;

    function automatic alu_op_e alu_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e branch_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b001:  op = ALU_NE;
            3'b100:  op = ALU_LT;
            3'b101:  op = ALU_GE;
            3'b110:  op = ALU_LTU;
            3'b111:  op = ALU_GEU;
            default: op = ALU_EQ;
        endcase
        return op;
    endfunction

    function automatic alu_op_e mul_op(input logic [1:0] f3);
        alu_op_e op;
        case (f3)
            2'b00:   op = ALU_MUL;
            2'b01:   op = ALU_MULH;
            2'b10:   op = ALU_MULHSU;
            default: op = ALU_MULHU;
        endcase
        return op;
    endfunction

    // An illegal instruction keeps flowing but must have no side effects
    function automatic ctrl_t force_illegal(input ctrl_t c);
        ctrl_t r;
        r               = c;
        r.illegal       = 1'b1;
        r.reg_write_en  = 1'b0;
        r.alu_en        = 1'b0;
        r.mul_en        = 1'b0;
        r.dmem_read_en  = 1'b0;
        r.dmem_write_en = 1'b0;
        r.imm_type      = IMM_NONE;
        return r;
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        c  = '0;
        case (instr[6:0])
            OP_LUI: begin
                c.reg_write_en      = 1'b1;
                c.imm_type          = IMM_U;
                c.alu_en            = 1'b1;
                c.alu_op            = ALU_PASS_B;
                c.alu_mul_data2_sel = 1'b1;
            end
            OP_AUIPC: begin
                c.reg_write_en    = 1'b1;
                c.imm_type        = IMM_U;
                c.pcadder_op2_sel = 1'b1;
                c.execute_out_sel = EX_PCADD;
            end
            OP_JAL: begin
                c.reg_write_en    = 1'b1;
                c.imm_type        = IMM_J;
                c.pcadder_op2_sel = 1'b1;
                c.execute_out_sel = EX_LINK;
            end
            OP_JALR: begin
                c.reg_read_en     = 2'b01;
                c.reg_write_en    = 1'b1;
                c.imm_type        = IMM_I;
                c.pcadder_op1_sel = 1'b1;
                c.pcadder_op2_sel = 1'b1;
                c.execute_out_sel = EX_LINK;
            end
            OP_BRANCH: begin
                c.reg_read_en     = 2'b11;
                c.imm_type        = IMM_B;
                c.alu_en          = 1'b1;
                c.alu_op          = branch_op(f3);
                c.pcadder_op2_sel = 1'b1;
            end
            OP_LOAD: begin
                c.reg_read_en       = 2'b01;
                c.reg_write_en      = 1'b1;
                c.imm_type          = IMM_I;
                c.alu_en            = 1'b1;
                c.alu_mul_data2_sel = 1'b1;
                c.dmem_read_en      = 1'b1;
                c.reg_writedata_sel = 1'b1;
            end
            OP_STORE: begin
                c.reg_read_en       = 2'b11;
                c.imm_type          = IMM_S;
                c.alu_en            = 1'b1;
                c.alu_mul_data2_sel = 1'b1;
                c.dmem_write_en     = 1'b1;
            end
            OP_IMM: begin
                c.reg_read_en       = 2'b01;
                c.reg_write_en      = 1'b1;
                c.imm_type          = IMM_I;
                c.alu_en            = 1'b1;
                c.alu_op            = alu_funct(f3, f7[5] && (f3 == 3'b101));
                c.alu_mul_data2_sel = 1'b1;
            end
            OP_REG: begin
                c.reg_read_en  = 2'b11;
                c.reg_write_en = 1'b1;
                if (f7 == 7'b0000001) begin
                    c.mul_en          = 1'b1;
                    c.alu_op          = mul_op(f3[1:0]);
                    c.execute_out_sel = EX_MUL;
                end else begin
                    c.alu_en = 1'b1;
                    c.alu_op = alu_funct(f3, f7[5]);
                end
            end
            default: c.illegal = 1'b1;
        endcase
        if (instr[11:7] == 5'd0) begin
            c.reg_write_en = 1'b0;
        end
        if (c.illegal) begin
            c = force_illegal(c);
        end
        return c;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e imm_type);
        logic [31:0] imm;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 2R1W register file with optional writeback forwarding
module regfile_bypass #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter bit BYPASS_EN = 1'b1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_en,
    input  logic [AW-1:0]   write_addr,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   read_addr1,
    input  logic [AW-1:0]   read_addr2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2
);

    logic [XLEN-1:0] mem [NUM_REGS];

    // storage: cleared on reset, x0 and out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en && write_addr != '0 && int'(write_addr) < NUM_REGS) begin
            mem[write_addr] <= write_data;
        end
    end

    // read ports: x0 and out-of-range read 0, same-cycle write forwarded when enabled
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_addr1 != '0 && int'(read_addr1) < NUM_REGS) begin
            if (BYPASS_EN && write_en && write_addr == read_addr1) begin
                read_data1 = write_data;
            end else begin
                read_data1 = mem[read_addr1];
            end
        end
        if (read_addr2 != '0 && int'(read_addr2) < NUM_REGS) begin
            if (BYPASS_EN && write_en && write_addr == read_addr2) begin
                read_data2 = write_data;
            end else begin
                read_data2 = mem[read_addr2];
            end
        end
    end

endmodule

// File: rtl/decode_stage_pipelined.sv
// rtl/decode_stage_pipelined.sv - RV32 decode stage with registered ID/EX slot
module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter bit BYPASS_EN = 1'b1,
    parameter bit HAZARD_EN = 1'b1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_write_en,
    input  logic [AW-1:0]   wb_write_addr,
    input  logic [XLEN-1:0] wb_write_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output ctrl_t           out_ctrl,
    output logic [AW-1:0]   out_rs1_addr,
    output logic [AW-1:0]   out_rs2_addr,
    output logic [AW-1:0]   out_rd_addr,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [XLEN-1:0] out_imm,
    output logic            stall
);

    logic [4:0]      rs1_field;
    logic [4:0]      rs2_field;
    logic [4:0]      rd_field;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            load_use;
    logic            slot_free;
    logic            accept;

    assign rs1_field = in_instr[19:15];
    assign rs2_field = in_instr[24:20];
    assign rd_field  = in_instr[11:7];

    // decode, then reject register fields beyond the implemented register count
    always_comb begin
        ctrl = decode_ctrl(in_instr);
        if ((ctrl.reg_read_en[0] && int'(rs1_field) >= NUM_REGS) ||
            (ctrl.reg_read_en[1] && int'(rs2_field) >= NUM_REGS) ||
            (ctrl.reg_write_en && int'(rd_field) >= NUM_REGS)) begin
            ctrl = force_illegal(ctrl);
        end
        imm = XLEN'($signed(gen_imm(in_instr, ctrl.imm_type)));
    end

    regfile_bypass #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .write_en   (wb_write_en),
        .write_addr (wb_write_addr),
        .write_data (wb_write_data),
        .read_addr1 (rs1_field[AW-1:0]),
        .read_addr2 (rs2_field[AW-1:0]),
        .read_data1 (rd1),
        .read_data2 (rd2)
    );

    // load in the slot whose destination this instruction needs: hold it back one cycle
    always_comb begin
        load_use = HAZARD_EN && in_valid && out_valid && out_ctrl.dmem_read_en &&
                   (out_rd_addr != '0) &&
                   ((ctrl.reg_read_en[0] && rs1_field[AW-1:0] == out_rd_addr) ||
                    (ctrl.reg_read_en[1] && rs2_field[AW-1:0] == out_rd_addr));
        stall     = load_use && !flush && !rst;
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && !stall && !flush && !rst;
        accept    = in_valid && in_ready;
    end

    // ID/EX slot: reset > flush > accept > drain; holds bit-exact otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_ctrl     <= '0;
            out_rs1_addr <= '0;
            out_rs2_addr <= '0;
            out_rd_addr  <= '0;
            out_rd1      <= '0;
            out_rd2      <= '0;
            out_imm      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_ctrl     <= ctrl;
            out_rs1_addr <= rs1_field[AW-1:0];
            out_rs2_addr <= rs2_field[AW-1:0];
            out_rd_addr  <= rd_field[AW-1:0];
            out_rd1      <= rd1;
            out_rd2      <= rd2;
            out_imm      <= imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb/tb_decode_stage_pipelined.sv - self-checking bench for decode_stage_pipelined
module tb_decode_stage_pipelined;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready, wb_we, wb16_we;
    logic [31:0] in_instr, in_pc, wb_data, wb16_data;
    logic [4:0]  wb_addr;
    logic [3:0]  wb16_addr;

    logic        in_ready, out_valid, stall;
    logic [31:0] out_pc, out_rd1, out_rd2, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    ctrl_t       out_ctrl;

    logic        n_in_ready, n_valid, n_stall;
    logic [31:0] n_pc, n_rd1, n_rd2, n_imm;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    ctrl_t       n_ctrl;

    logic        s_in_ready, s_valid, s_stall;
    logic [31:0] s_pc, s_rd1, s_rd2, s_imm;
    logic [3:0]  s_rs1, s_rs2, s_rd;
    ctrl_t       s_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage_pipelined dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .wb_write_en(wb_we), .wb_write_addr(wb_addr),
        .wb_write_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_rs1_addr(out_rs1), .out_rs2_addr(out_rs2), .out_rd_addr(out_rd),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .stall(stall)
    );

    decode_stage_pipelined #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .wb_write_en(wb_we), .wb_write_addr(wb_addr),
        .wb_write_data(wb_data), .out_valid(n_valid), .out_ready(out_ready), .out_pc(n_pc),
        .out_ctrl(n_ctrl), .out_rs1_addr(n_rs1), .out_rs2_addr(n_rs2), .out_rd_addr(n_rd),
        .out_rd1(n_rd1), .out_rd2(n_rd2), .out_imm(n_imm), .stall(n_stall)
    );

    decode_stage_pipelined #(.NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .wb_write_en(wb16_we), .wb_write_addr(wb16_addr),
        .wb_write_data(wb16_data), .out_valid(s_valid), .out_ready(out_ready), .out_pc(s_pc),
        .out_ctrl(s_ctrl), .out_rs1_addr(s_rs1), .out_rs2_addr(s_rs2), .out_rd_addr(s_rd),
        .out_rd1(s_rd1), .out_rd2(s_rd2), .out_imm(s_imm), .stall(s_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference for the random phase ----------------
    typedef struct {
        logic [31:0] pc, imm, rd1, rd2, rd1_nb, rd2_nb;
        logic [4:0]  rs1, rs2, rd;
        bit          illegal, rwe, load;
    } slot_t;

    logic [31:0] m_regs [32];
    bit          m_valid;
    slot_t       m_slot;

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int s;
        s = int'(ins);
        case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR: return 32'(s >>> 20);
            OP_STORE:  return 32'(((s >>> 25) << 5) | int'(ins[11:7]));
            OP_BRANCH: return 32'(((s >>> 31) << 12) | (int'(ins[7]) << 11) |
                                  (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
            OP_LUI, OP_AUIPC: return ins & 32'hFFFF_F000;
            OP_JAL:    return 32'(((s >>> 31) << 20) | (int'(ins[19:12]) << 12) |
                                  (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit fwd);
        if (a == 5'd0) return 32'h0;
        if (fwd && wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0: op = OP_LUI;    1: op = OP_AUIPC; 2: op = OP_JAL;   3: op = OP_JALR;
            4: op = OP_BRANCH; 5: op = OP_LOAD;  6: op = OP_STORE; 7: op = OP_IMM;
            8: op = OP_REG;    default: op = 7'b1111111;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), op};
    endfunction

    // ---------------- directed decode vectors ----------------
    typedef struct {
        logic [31:0] instr, imm, rd1;
        logic [4:0]  rd;
        bit          illegal, rwe, dmem_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{32'hFFF28313, 32'hFFFF_FFFF, 32'h0000_00AA, 5'd6,  1'b0, 1'b1, 1'b0}; // addi x6,x5,-1
        vecs[1] = '{32'h123450B7, 32'h1234_5000, 32'h0,         5'd1,  1'b0, 1'b1, 1'b0}; // lui x1
        vecs[2] = '{32'hFE20AE23, 32'hFFFF_FFFC, 32'h0,         5'd28, 1'b0, 1'b0, 1'b0}; // sw x2,-4(x1)
        vecs[3] = '{32'h00208463, 32'h0000_0008, 32'h0,         5'd8,  1'b0, 1'b0, 1'b0}; // beq +8
        vecs[4] = '{32'hFFDFF0EF, 32'hFFFF_FFFC, 32'h0,         5'd1,  1'b0, 1'b1, 1'b0}; // jal x1,-4
        vecs[5] = '{32'h00208033, 32'h0,         32'h0,         5'd0,  1'b0, 1'b0, 1'b0}; // add x0
        vecs[6] = '{32'hFFFFFFFF, 32'h0,         32'h0,         5'd31, 1'b1, 1'b0, 1'b0}; // bad opcode
        vecs[7] = '{32'h80000197, 32'h8000_0000, 32'h0,         5'd3,  1'b0, 1'b1, 1'b0}; // auipc x3
        vecs[8] = '{32'h0000A483, 32'h0,         32'h0,         5'd9,  1'b0, 1'b1, 1'b1}; // lw x9,0(x1)

        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h0; flush = 1'b0;
        out_ready = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        wb16_we = 1'b0; wb16_addr = '0; wb16_data = '0;

        // reset
        clk1(); clk1();
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        clk1();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // x5 = 0xAA, then the decode table
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
        clk1();
        wb_we = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            chk("tbl_in_ready", {31'b0, in_ready}, 32'h1);
            clk1();
            in_valid = 1'b0;
            chk("tbl_out_valid", {31'b0, out_valid}, 32'h1);
            chk("tbl_pc", out_pc, 32'h1000 + 32'(i * 4));
            chk("tbl_imm", out_imm, vecs[i].imm);
            chk("tbl_rd1", out_rd1, vecs[i].rd1);
            chk("tbl_rd_addr", {27'b0, out_rd}, {27'b0, vecs[i].rd});
            chk("tbl_illegal", {31'b0, out_ctrl.illegal}, {31'b0, vecs[i].illegal});
            chk("tbl_rwe", {31'b0, out_ctrl.reg_write_en}, {31'b0, vecs[i].rwe});
            chk("tbl_dmem_rd", {31'b0, out_ctrl.dmem_read_en}, {31'b0, vecs[i].dmem_rd});
        end
        clk1();

        // bypass: x7 written in the same cycle add x8,x7,x0 is accepted
        in_valid = 1'b1; in_instr = 32'h00038433; in_pc = 32'h200;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        clk1();
        in_valid = 1'b0; wb_we = 1'b0;
        chk("bypass_rd1", out_rd1, 32'h1234);
        chk("nobypass_rd1", n_rd1, 32'h0);

        // load-use: lw x9 then add x10,x9,x2 -> one stall, one bubble
        in_valid = 1'b1; in_instr = 32'h0000A483; in_pc = 32'h300;
        clk1();
        in_instr = 32'h00248533; in_pc = 32'h304;
        @(negedge clk);
        chk("lu_stall", {31'b0, stall}, 32'h1);
        chk("lu_in_ready", {31'b0, in_ready}, 32'h0);
        clk1();
        chk("lu_bubble", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lu_stall_off", {31'b0, stall}, 32'h0);
        chk("lu_ready_back", {31'b0, in_ready}, 32'h1);
        clk1();
        in_valid = 1'b0;
        chk("lu_add_valid", {31'b0, out_valid}, 32'h1);
        chk("lu_add_pc", out_pc, 32'h304);
        chk("lu_add_rd", {27'b0, out_rd}, 32'd10);
        // load into x0 never stalls
        in_valid = 1'b1; in_instr = 32'h0000A003; in_pc = 32'h310;
        clk1();
        in_instr = 32'h00200533; in_pc = 32'h314;
        @(negedge clk);
        chk("lu_x0_stall", {31'b0, stall}, 32'h0);
        chk("lu_x0_ready", {31'b0, in_ready}, 32'h1);
        clk1();
        in_valid = 1'b0;
        chk("lu_x0_pc", out_pc, 32'h314);

        // backpressure for three cycles
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
        clk1();
        out_ready = 1'b0; in_instr = 32'h00200113; in_pc = 32'h404;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
            chk("bp_valid", {31'b0, out_valid}, 32'h1);
            chk("bp_pc", out_pc, 32'h400);
            chk("bp_imm", out_imm, 32'h1);
            clk1();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
        clk1();
        in_valid = 1'b0;
        chk("bp_next_pc", out_pc, 32'h404);
        chk("bp_next_imm", out_imm, 32'h2);
        clk1();
        chk("bp_drain", {31'b0, out_valid}, 32'h0);

        // flush with a valid slot; the x3 writeback still commits
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500;
        clk1();
        in_instr = 32'h00200113; in_pc = 32'h504; flush = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        @(negedge clk);
        chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
        clk1();
        flush = 1'b0; wb_we = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b1; in_instr = 32'h00018233; in_pc = 32'h508;
        clk1();
        in_valid = 1'b0;
        chk("fl_wb_commit", out_rd1, 32'h33);
        chk("fl_next_pc", out_pc, 32'h508);
        // flush beats a load-use stall
        in_valid = 1'b1; in_instr = 32'h0000A483; in_pc = 32'h510;
        clk1();
        in_instr = 32'h00248533; flush = 1'b1;
        @(negedge clk);
        chk("fl_stall_hidden", {31'b0, stall}, 32'h0);
        chk("fl_stall_ready", {31'b0, in_ready}, 32'h0);
        clk1();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_stall_valid", {31'b0, out_valid}, 32'h0);
        clk1();

        // RV32E instance: x0 write ignored, x17 illegal
        wb16_we = 1'b1; wb16_addr = 4'd0; wb16_data = 32'hDEAD;
        clk1();
        wb16_we = 1'b0;
        in_valid = 1'b1; in_instr = 32'h000002B3; in_pc = 32'h600;
        clk1();
        in_valid = 1'b0;
        chk("e_valid", {31'b0, s_valid}, 32'h1);
        chk("e_x0_rd1", s_rd1, 32'h0);
        chk("e_x0_rd2", s_rd2, 32'h0);
        in_valid = 1'b1; in_instr = 32'h002088B3; in_pc = 32'h604;
        clk1();
        in_valid = 1'b0;
        chk("e_illegal", {31'b0, s_ctrl.illegal}, 32'h1);
        chk("e_rwe", {31'b0, s_ctrl.reg_write_en}, 32'h0);
        chk("e_imm", s_imm, 32'h0);
        chk("i_legal", {31'b0, out_ctrl.illegal}, 32'h0);
        chk("i_rwe", {31'b0, out_ctrl.reg_write_en}, 32'h1);
        clk1();

        // randomized run against the reference model, from a fresh reset
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [6:0] op;
            logic [4:0] rs1, rs2;
            bit         us1, us2, e_stall, e_ready;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_we     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            @(negedge clk);
            op  = in_instr[6:0];
            rs1 = in_instr[19:15];
            rs2 = in_instr[24:20];
            us1 = op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
            us2 = op inside {OP_BRANCH, OP_STORE, OP_REG};
            e_stall = in_valid && m_valid && m_slot.load && m_slot.rd != 0 && !flush &&
                      ((us1 && rs1 == m_slot.rd) || (us2 && rs2 == m_slot.rd));
            e_ready = (!m_valid || out_ready) && !e_stall && !flush;
            chk("rnd_stall", {31'b0, stall}, {31'b0, e_stall});
            chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, e_ready});
            chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("rnd_pc", out_pc, m_slot.pc);
                chk("rnd_imm", out_imm, m_slot.imm);
                chk("rnd_rd1", out_rd1, m_slot.rd1);
                chk("rnd_rd2", out_rd2, m_slot.rd2);
                chk("rnd_nb_rd1", n_rd1, m_slot.rd1_nb);
                chk("rnd_nb_rd2", n_rd2, m_slot.rd2_nb);
                chk("rnd_rs1", {27'b0, out_rs1}, {27'b0, m_slot.rs1});
                chk("rnd_rs2", {27'b0, out_rs2}, {27'b0, m_slot.rs2});
                chk("rnd_rd", {27'b0, out_rd}, {27'b0, m_slot.rd});
                chk("rnd_illegal", {31'b0, out_ctrl.illegal}, {31'b0, m_slot.illegal});
                chk("rnd_rwe", {31'b0, out_ctrl.reg_write_en}, {31'b0, m_slot.rwe});
                chk("rnd_load", {31'b0, out_ctrl.dmem_read_en}, {31'b0, m_slot.load});
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && e_ready) begin
                m_valid        = 1'b1;
                m_slot.pc      = in_pc;
                m_slot.imm     = m_imm(in_instr);
                m_slot.rd1     = m_read(rs1, 1'b1);
                m_slot.rd2     = m_read(rs2, 1'b1);
                m_slot.rd1_nb  = m_read(rs1, 1'b0);
                m_slot.rd2_nb  = m_read(rs2, 1'b0);
                m_slot.rs1     = rs1;
                m_slot.rs2     = rs2;
                m_slot.rd      = in_instr[11:7];
                m_slot.illegal = !legal_op(op);
                m_slot.rwe     = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG})
                                 && in_instr[11:7] != 5'd0;
                m_slot.load    = (op == OP_LOAD);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
            clk1();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
